// File: rtl/reg_file_param_if.sv
// Bus between the decode/writeback side (master) and the register file (slave).
interface reg_file_param_if #(
  parameter int unsigned DATA_W = 15,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WRD;
  logic              WE;
  logic              CLR;
  logic              ERR_CLR;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              RV1;
  logic              RV2;
  logic              ERR;

  modport master (
    output RA1, RA2, WA, WRD, WE, CLR, ERR_CLR,
    input  RD1, RD2, RV1, RV2, ERR
  );

  modport slave (
    input  RA1, RA2, WA, WRD, WE, CLR, ERR_CLR,
    output RD1, RD2, RV1, RV2, ERR
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with per-entry valid bits, bulk clear,
// optional write-to-read bypass, optional registered reads and a sticky address-error flag.
module reg_file_param #(
  parameter int unsigned DATA_W = 15,
  parameter int unsigned DEPTH  = 9,
  parameter int unsigned ADDR_W = 4,
  parameter bit          BYPASS = 1'b1,
  parameter bit          RD_REG = 1'b0
) (
  input  logic            CLK,
  input  logic            RST_N,
  reg_file_param_if.slave bus
);

  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CMP_W-1:0] DEPTH_X = CMP_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic              r_err;

  logic              w_wr_ok;
  logic              w_byp_ok;
  logic              w_err_set;
  logic              w_ra1_ok;
  logic              w_ra2_ok;
  logic              w_wa_ok;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_rv1;
  logic              w_rv2;

  assign w_ra1_ok  = {1'b0, bus.RA1} < DEPTH_X;
  assign w_ra2_ok  = {1'b0, bus.RA2} < DEPTH_X;
  assign w_wa_ok   = {1'b0, bus.WA}  < DEPTH_X;
  assign w_wr_ok   = bus.WE && !bus.CLR && w_wa_ok;
  // Forwarding is held off during reset so outputs read 0 while RST_N is low.
  assign w_byp_ok  = BYPASS && w_wr_ok && RST_N;
  assign w_err_set = (bus.WE && !w_wa_ok) || !w_ra1_ok || !w_ra2_ok;

  // Read ports: out-of-range reads return 0/invalid, bypass takes precedence over storage.
  always_comb begin
    w_rd1 = '0;
    w_rv1 = 1'b0;
    w_rd2 = '0;
    w_rv2 = 1'b0;
    if (w_ra1_ok) begin
      if (w_byp_ok && (bus.RA1 == bus.WA)) begin
        w_rd1 = bus.WRD;
        w_rv1 = 1'b1;
      end else begin
        w_rd1 = r_mem[bus.RA1[IDX_W-1:0]];
        w_rv1 = r_valid[bus.RA1[IDX_W-1:0]];
      end
    end
    if (w_ra2_ok) begin
      if (w_byp_ok && (bus.RA2 == bus.WA)) begin
        w_rd2 = bus.WRD;
        w_rv2 = 1'b1;
      end else begin
        w_rd2 = r_mem[bus.RA2[IDX_W-1:0]];
        w_rv2 = r_valid[bus.RA2[IDX_W-1:0]];
      end
    end
  end

  // Storage and valid bits; clear wins over a simultaneous write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mem   <= '{default: '0};
      r_valid <= '0;
    end else if (bus.CLR) begin
      r_mem   <= '{default: '0};
      r_valid <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.WA[IDX_W-1:0]]   <= bus.WRD;
      r_valid[bus.WA[IDX_W-1:0]] <= 1'b1;
    end
  end

  // Sticky error: a new fault on the same edge overrides ERR_CLR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (bus.ERR_CLR) begin
      r_err <= 1'b0;
    end
  end

  assign bus.ERR = r_err;

  generate
    if (RD_REG) begin : g_rd_reg
      logic [DATA_W-1:0] r_rd1;
      logic [DATA_W-1:0] r_rd2;
      logic              r_rv1;
      logic              r_rv2;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_rd1 <= '0;
          r_rd2 <= '0;
          r_rv1 <= 1'b0;
          r_rv2 <= 1'b0;
        end else begin
          r_rd1 <= w_rd1;
          r_rd2 <= w_rd2;
          r_rv1 <= w_rv1;
          r_rv2 <= w_rv2;
        end
      end

      assign bus.RD1 = r_rd1;
      assign bus.RD2 = r_rd2;
      assign bus.RV1 = r_rv1;
      assign bus.RV2 = r_rv2;
    end else begin : g_rd_comb
      assign bus.RD1 = w_rd1;
      assign bus.RD2 = w_rd2;
      assign bus.RV1 = w_rv1;
      assign bus.RV2 = w_rv2;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: bypass/comb, no-bypass/comb and registered 32x16 variants
// checked against a per-cycle reference model plus directed literal expectations.
module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic chk_en;
  int   n_tests = 0;
  int   n_fail  = 0;

  reg_file_param_if #(.DATA_W(15), .ADDR_W(4)) ifa ();
  reg_file_param_if #(.DATA_W(15), .ADDR_W(4)) ifb ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(4)) ifc ();

  // Shared stimulus for the two 15x9 instances
  logic [3:0]  s_ra1, s_ra2, s_wa;
  logic [14:0] s_wrd;
  logic        s_we, s_clr, s_eclr;
  // Stimulus for the 32x16 registered instance
  logic [3:0]  c_ra1, c_ra2, c_wa;
  logic [31:0] c_wrd;
  logic        c_we, c_clr, c_eclr;

  assign ifa.RA1 = s_ra1;  assign ifa.RA2 = s_ra2;  assign ifa.WA = s_wa;
  assign ifa.WRD = s_wrd;  assign ifa.WE  = s_we;   assign ifa.CLR = s_clr;
  assign ifa.ERR_CLR = s_eclr;
  assign ifb.RA1 = s_ra1;  assign ifb.RA2 = s_ra2;  assign ifb.WA = s_wa;
  assign ifb.WRD = s_wrd;  assign ifb.WE  = s_we;   assign ifb.CLR = s_clr;
  assign ifb.ERR_CLR = s_eclr;
  assign ifc.RA1 = c_ra1;  assign ifc.RA2 = c_ra2;  assign ifc.WA = c_wa;
  assign ifc.WRD = c_wrd;  assign ifc.WE  = c_we;   assign ifc.CLR = c_clr;
  assign ifc.ERR_CLR = c_eclr;

  reg_file_param #(.DATA_W(15), .DEPTH(9), .ADDR_W(4), .BYPASS(1'b1), .RD_REG(1'b0))
    dut_a (.CLK(clk), .RST_N(rst_n), .bus(ifa));
  reg_file_param #(.DATA_W(15), .DEPTH(9), .ADDR_W(4), .BYPASS(1'b0), .RD_REG(1'b0))
    dut_b (.CLK(clk), .RST_N(rst_n), .bus(ifb));
  reg_file_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .BYPASS(1'b1), .RD_REG(1'b1))
    dut_c (.CLK(clk), .RST_N(rst_n), .bus(ifc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for the 9-entry files: arrays of contents and valid flags
  logic [14:0] m_mem [9];
  logic        m_val [9];
  logic        m_err;

  function automatic logic [15:0] exp_ab(input logic [3:0] ra, input bit byp);
    if (ra >= 4'd9) return 16'h0;
    if (byp && rst_n && s_we && !s_clr && (s_wa < 4'd9) && (s_wa == ra)) return {1'b1, s_wrd};
    return {m_val[ra], m_mem[ra]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin m_mem[i] = '0; m_val[i] = 1'b0; end
      m_err = 1'b0;
    end else begin
      if ((s_we && s_wa >= 4'd9) || s_ra1 >= 4'd9 || s_ra2 >= 4'd9) m_err = 1'b1;
      else if (s_eclr) m_err = 1'b0;
      if (s_clr) begin
        for (int i = 0; i < 9; i++) begin m_mem[i] = '0; m_val[i] = 1'b0; end
      end else if (s_we && s_wa < 4'd9) begin
        m_mem[s_wa] = s_wrd;
        m_val[s_wa] = 1'b1;
      end
    end
  end

  // Reference model for the registered 16-entry file: outputs lag the read by one edge
  logic [31:0] k_mem [16];
  logic        k_val [16];
  logic [32:0] e_c1, e_c2;

  function automatic logic [32:0] exp_c(input logic [3:0] ra);
    if (c_we && !c_clr && c_wa == ra) return {1'b1, c_wrd};
    return {k_val[ra], k_mem[ra]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin k_mem[i] = '0; k_val[i] = 1'b0; end
      e_c1 = '0;
      e_c2 = '0;
    end else begin
      e_c1 = exp_c(c_ra1);
      e_c2 = exp_c(c_ra2);
      if (c_clr) begin
        for (int i = 0; i < 16; i++) begin k_mem[i] = '0; k_val[i] = 1'b0; end
      end else if (c_we) begin
        k_mem[c_wa] = c_wrd;
        k_val[c_wa] = 1'b1;
      end
    end
  end

  // Per-cycle comparison of all three instances against the models
  always @(negedge clk) begin : cmp
    logic [15:0] e;
    if (chk_en) begin
      e = exp_ab(s_ra1, 1'b1);
      chk("a_rd1", 32'(ifa.RD1), 32'(e[14:0]));  chk("a_rv1", 32'(ifa.RV1), 32'(e[15]));
      e = exp_ab(s_ra2, 1'b1);
      chk("a_rd2", 32'(ifa.RD2), 32'(e[14:0]));  chk("a_rv2", 32'(ifa.RV2), 32'(e[15]));
      e = exp_ab(s_ra1, 1'b0);
      chk("b_rd1", 32'(ifb.RD1), 32'(e[14:0]));  chk("b_rv1", 32'(ifb.RV1), 32'(e[15]));
      e = exp_ab(s_ra2, 1'b0);
      chk("b_rd2", 32'(ifb.RD2), 32'(e[14:0]));  chk("b_rv2", 32'(ifb.RV2), 32'(e[15]));
      chk("a_err", 32'(ifa.ERR), 32'(m_err));
      chk("b_err", 32'(ifb.ERR), 32'(m_err));
      chk("c_rd1", ifc.RD1, e_c1[31:0]);  chk("c_rv1", 32'(ifc.RV1), 32'(e_c1[32]));
      chk("c_rd2", ifc.RD2, e_c2[31:0]);  chk("c_rv2", 32'(ifc.RV2), 32'(e_c2[32]));
      chk("c_err", 32'(ifc.ERR), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; chk_en = 1'b0;
    s_ra1 = '0; s_ra2 = '0; s_wa = '0; s_wrd = '0; s_we = 1'b0; s_clr = 1'b0; s_eclr = 1'b0;
    c_ra1 = '0; c_ra2 = '0; c_wa = '0; c_wrd = '0; c_we = 1'b0; c_clr = 1'b0; c_eclr = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_rd1", 32'(ifa.RD1), 32'd0);
    chk("rst_a_rv1", 32'(ifa.RV1), 32'd0);
    chk("rst_a_err", 32'(ifa.ERR), 32'd0);
    chk("rst_c_rd1", ifc.RD1, 32'd0);
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // Write 3 and read it on both ports
    s_we = 1'b1; s_wa = 4'd3; s_wrd = 15'h1234; s_ra1 = 4'd3; s_ra2 = 4'd3;
    #1;
    chk("byp_w3_a", 32'(ifa.RD1), 32'h1234);
    chk("nobyp_w3_b", 32'(ifb.RD1), 32'h0);
    step();
    s_we = 1'b0;
    #1;
    chk("rd_w3_a1", 32'(ifa.RD1), 32'h1234);
    chk("rd_w3_a2", 32'(ifa.RD2), 32'h1234);
    chk("rv_w3_a2", 32'(ifa.RV2), 32'd1);
    chk("rd_w3_b1", 32'(ifb.RD1), 32'h1234);
    s_ra1 = 4'd4;
    #1;
    chk("rd_e4_a", 32'(ifa.RD1), 32'h0);
    chk("rv_e4_a", 32'(ifa.RV1), 32'd0);

    // Bypass vs. stored value on entry 5
    s_we = 1'b1; s_wa = 4'd5; s_wrd = 15'h0123; s_ra1 = 4'd0;
    step();
    s_wrd = 15'h7FFF; s_ra1 = 4'd5; s_ra2 = 4'd5;
    #1;
    chk("byp5_a1", 32'(ifa.RD1), 32'h7FFF);
    chk("byp5_a2", 32'(ifa.RD2), 32'h7FFF);
    chk("old5_b1", 32'(ifb.RD1), 32'h0123);
    step();
    s_we = 1'b0;
    #1;
    chk("new5_b1", 32'(ifb.RD1), 32'h7FFF);

    // Error flag: bad write, bad read, clear, clear racing a new fault
    s_ra1 = 4'd0; s_ra2 = 4'd0;
    s_we = 1'b1; s_wa = 4'd9; s_wrd = 15'h3333;
    #1;
    chk("err_not_yet", 32'(ifa.ERR), 32'd0);
    step();
    s_we = 1'b0;
    #1;
    chk("err_wr9", 32'(ifa.ERR), 32'd1);
    s_ra2 = 4'd15;
    #1;
    chk("rd_oob15", 32'(ifa.RD2), 32'h0);
    chk("rv_oob15", 32'(ifa.RV2), 32'd0);
    step();
    s_ra2 = 4'd0; s_eclr = 1'b1;
    step();
    s_eclr = 1'b0;
    #1;
    chk("err_cleared", 32'(ifa.ERR), 32'd0);
    s_eclr = 1'b1; s_ra1 = 4'd12;
    step();
    s_eclr = 1'b0; s_ra1 = 4'd0;
    #1;
    chk("err_set_wins", 32'(ifb.ERR), 32'd1);
    s_eclr = 1'b1;
    step();
    s_eclr = 1'b0;

    // Fill every entry, then clear with a colliding write
    for (int i = 0; i < 9; i++) begin
      s_we = 1'b1; s_wa = 4'(i); s_wrd = 15'(15'h0100 + i); s_ra1 = 4'(i); s_ra2 = 4'(8 - i);
      step();
    end
    s_we = 1'b1; s_clr = 1'b1; s_wa = 4'd0; s_wrd = 15'h0AAA; s_ra1 = 4'd0; s_ra2 = 4'd8;
    #1;
    chk("clr_no_byp", 32'(ifa.RD1), 32'h0100);
    chk("full_e8", 32'(ifa.RD2), 32'h0108);
    step();
    s_we = 1'b0; s_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_ra1 = 4'(i);
      #1;
      chk("clr_rd", 32'(ifa.RD1), 32'h0);
      chk("clr_rv", 32'(ifa.RV1), 32'd0);
      step();
    end
    chk("clr_keeps_err", 32'(ifa.ERR), 32'd0);

    // Reset in the middle of a write
    s_ra1 = 4'd2; s_we = 1'b1; s_wa = 4'd2; s_wrd = 15'h0555;
    #1;
    chk("pre_rst_byp", 32'(ifa.RD1), 32'h0555);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_a", 32'(ifa.RD1), 32'h0);
    chk("rst_mid_rv", 32'(ifa.RV1), 32'd0);
    step();
    s_we = 1'b0; rst_n = 1'b1;
    step();
    chk("lost_write", 32'(ifb.RD1), 32'h0);
    chk("lost_valid", 32'(ifb.RV1), 32'd0);

    // Registered 32x16 instance: one-cycle read latency
    c_we = 1'b1; c_wa = 4'd15; c_wrd = 32'hDEADBEEF;
    step();
    c_we = 1'b0; c_ra1 = 4'd15;
    #1;
    chk("c_lat0", ifc.RD1, 32'h0);
    step();
    chk("c_lat1", ifc.RD1, 32'hDEADBEEF);
    chk("c_lat1_rv", 32'(ifc.RV1), 32'd1);
    c_we = 1'b1; c_wa = 4'd7; c_wrd = 32'hCAFEF00D; c_ra2 = 4'd7;
    #1;
    chk("c_byp_pre", ifc.RD2, 32'h0);
    step();
    c_we = 1'b0;
    #1;
    chk("c_byp_reg", ifc.RD2, 32'hCAFEF00D);
    c_clr = 1'b1;
    step();
    c_clr = 1'b0;
    chk("c_clr_lag", ifc.RD1, 32'hDEADBEEF);
    step();
    chk("c_clr_vis", ifc.RD1, 32'h0);
    c_we = 1'b1; c_wa = 4'd15; c_wrd = 32'h13579BDF;
    step();
    c_we = 1'b0;
    step();
    chk("c_rewrite", ifc.RD1, 32'h13579BDF);
    rst_n = 1'b0;
    #1;
    chk("c_async_rst", ifc.RD1, 32'h0);
    chk("c_async_rv", 32'(ifc.RV1), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
